branch_target_buffer_assoc: RTL and testbench
=============================================

# branch_target_buffer_assoc

Parametrised, set-associative branch target buffer with per-entry local 2-bit predictors. It sits between the fetch (F) and execute (E) stages. Each cycle it performs a combinational F-stage lookup of predicted direction and target. On the clock edge it applies the E-stage resolved outcome: allocate, retarget, or counter update. It generalises the direct-mapped buffer to tagged N-way sets with LRU replacement, and distinguishes conditional branches from unconditional jumps.

## Interface
- INDEX_WIDTH, 6, set index bits; SETS = 2^INDEX_WIDTH
- TAG_WIDTH, 8, stored tag bits
- WAYS, 2, associativity; legal values 1 or 2
- LOCAL_SRC_WIDTH, 2, local predictors per entry = 2^LOCAL_SRC_WIDTH
- clk_i  in  1  clock; one clock domain
- reset_n_i  in  1  asynchronous, active-low reset
- pc_f_i  in  32  fetch PC
- pc_e_i  in  32  execute-stage branch PC
- pc_target_e_i  in  32  resolved target
- local_src_i  in  LOCAL_SRC_WIDTH  local predictor select; shared by F and E
- branch_op_e_i  in  2  00 none, 01 conditional branch, 10 jump, 11 treated as none
- pc_src_res_e_i  in  1  resolved taken
- target_match_i  in  1  E-stage predicted target equalled actual target
- pc_src_pred_f_o  out  1  predicted taken
- pred_pc_target_f_o  out  32  predicted target
- hit_f_o  out  1  F lookup hit

## Operation
- Address split:
  - index = pc[INDEX_WIDTH+1:2]
  - tag = pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2]
- Entry fields: valid, tag, 32-bit target, 2^LOCAL_SRC_WIDTH 2-bit counters. Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Each set has one LRU bit, used only when WAYS=2.
- F lookup is combinational from registered state:
  - Hit = valid and tag equal in any way.
  - On hit: pc_src_pred_f_o = selected counter[1]; pred_pc_target_f_o = way target.
  - On miss: all outputs 0.
- E update when branch_op_e_i is 01 or 10. The taken value is pc_src_res_e_i for 01 and forced to 1 for 10.
  - Hit with target_match_i=1: selected counter saturating inc/dec for 01, or set to 11 for 10. Target unchanged.
  - Hit with target_match_i=0: target := pc_target_e_i. All counters := 01, then the selected counter is updated with taken (01→10 or 01→00; forced 11 for jump).
  - Miss: victim is the lowest invalid way, else the LRU way. Write valid, tag, target, and counters as on retarget.
  - WAYS=2: LRU bit := the way not touched. WAYS=1: always way 0.
- branch_op_e_i 00 or 11: no state change.

## Timing
- Lookup has zero-cycle latency, combinational in pc_f_i and local_src_i.
- Updates are visible to F the cycle after the edge.
- Same-cycle F read and E write to one entry: F sees pre-update contents.
- E index equal to F index in the same cycle is legal; no stall.
- Async reset clears all valid bits, sets LRU bits to 0, counters to 01, and targets to 0.
  - Outputs go to 0 immediately and stay 0 until the first allocation.
  - Reset asserted mid-update discards the update.
- Saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.

## Configuration
- BTB_STATS_EN defined: adds two outputs, each incrementing at the update edge and saturating at 32'hFFFF_FFFF. Both reset to 0.
  - update_cnt_o [31:0]: +1 per update.
  - mispredict_cnt_o [31:0]: +1 when (E-stage pre-update pred ≠ taken) or (taken and not (hit and target_match_i)). E-stage pred = hit & counter[1].
- BTB_STATS_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Reset: reset_n_i=0 with pc_f_i=0x0 and 0x100 → hit_f_o=0, pc_src_pred_f_o=0, pred_pc_target_f_o=0. Release, then idle 5 cycles → outputs unchanged.
- Allocate: branch_op 01, pc_e=0x40, target 0x200, taken, local_src=0 → next cycle pc_f=0x40 gives hit=1, pred=1 (counter 10), target 0x200. local_src=1 → pred=0 (counter 01).
- Saturation: three further taken updates, then one not-taken → pred=1 (11→10). A second not-taken → pred=0.
- LRU (WAYS=2):
  - Allocate 0x40, then 0x140, then update 0x40 (same set).
  - Allocate 0x240 → pc_f=0x140 misses; 0x40 and 0x240 hit.
- Retarget: entry 0x40 hit with target_match=0, target 0x300, not taken → target 0x300, pred=0 for every local_src value.
- Jump and stats (BTB_STATS_EN): op 10, pc_src_res=0 on a new PC 0x80 → pred=1, counter 11, update_cnt_o=1, mispredict_cnt_o=1. A repeat with target_match=1 → update_cnt_o=2, mispredict_cnt_o=1.

Source files
------------

// File: rtl/branch_target_buffer_assoc.sv
// Set-associative BTB (1 or 2 ways, per-set LRU) with per-entry local 2-bit predictors.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer_assoc #(
    parameter int unsigned INDEX_WIDTH     = 6,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned WAYS            = 2,
    parameter int unsigned LOCAL_SRC_WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [31:0]                pc_f_i,
    input  logic [31:0]                pc_e_i,
    input  logic [31:0]                pc_target_e_i,
    input  logic [LOCAL_SRC_WIDTH-1:0] local_src_i,
    input  logic [1:0]                 branch_op_e_i,
    input  logic                       pc_src_res_e_i,
    input  logic                       target_match_i,
    output logic                       pc_src_pred_f_o,
    output logic [31:0]                pred_pc_target_f_o,
    output logic                       hit_f_o
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]                update_cnt_o,
    output logic [31:0]                mispredict_cnt_o
`endif
);

    localparam int unsigned SETS   = 1 << INDEX_WIDTH;
    localparam int unsigned LOCALS = 1 << LOCAL_SRC_WIDTH;
    localparam int unsigned WAY_W  = 1;

    logic                 valid_q  [WAYS][SETS];
    logic [TAG_WIDTH-1:0] tag_q    [WAYS][SETS];
    logic [31:0]          target_q [WAYS][SETS];
    logic [1:0]           cnt_q    [WAYS][SETS][LOCALS];
    logic                 lru_q    [SETS];

    logic [INDEX_WIDTH-1:0] idx_f, idx_e;
    logic [TAG_WIDTH-1:0]   tag_f, tag_e;
    logic                   hit_f, hit_e, has_invalid;
    logic [WAY_W-1:0]       way_f, way_e, invalid_way, victim;
    logic                   is_cond, is_jump, do_update, taken_e, reinit;
    logic [1:0]             cnt_e_old, cnt_e_new;
    logic                   unused_pc;

    assign idx_f = pc_f_i[INDEX_WIDTH+1:2];
    assign tag_f = pc_f_i[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
    assign idx_e = pc_e_i[INDEX_WIDTH+1:2];
    assign tag_e = pc_e_i[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
    assign unused_pc = ^{pc_f_i[31:INDEX_WIDTH+TAG_WIDTH+2], pc_f_i[1:0],
                         pc_e_i[31:INDEX_WIDTH+TAG_WIDTH+2], pc_e_i[1:0]};

    // Way search runs downwards so the lowest matching/invalid way wins.
    always_comb begin
        hit_f       = 1'b0;
        way_f       = '0;
        hit_e       = 1'b0;
        way_e       = '0;
        has_invalid = 1'b0;
        invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][idx_f] && tag_q[w][idx_f] == tag_f) begin
                hit_f = 1'b1;
                way_f = WAY_W'(w);
            end
            if (valid_q[w][idx_e] && tag_q[w][idx_e] == tag_e) begin
                hit_e = 1'b1;
                way_e = WAY_W'(w);
            end
            if (!valid_q[w][idx_e]) begin
                has_invalid = 1'b1;
                invalid_way = WAY_W'(w);
            end
        end
    end

    assign hit_f_o            = hit_f;
    assign pc_src_pred_f_o    = hit_f & cnt_q[way_f][idx_f][local_src_i][1];
    assign pred_pc_target_f_o = hit_f ? target_q[way_f][idx_f] : 32'h0;

    assign is_cond   = (branch_op_e_i == 2'b01);
    assign is_jump   = (branch_op_e_i == 2'b10);
    assign do_update = is_cond | is_jump;
    assign taken_e   = is_jump | pc_src_res_e_i;
    assign reinit    = !(hit_e && target_match_i);
    assign cnt_e_old = cnt_q[way_e][idx_e][local_src_i];

    always_comb begin
        victim = '0;
        if (hit_e) begin
            victim = way_e;
        end else if (has_invalid) begin
            victim = invalid_way;
        end else if (WAYS == 2) begin
            victim = WAY_W'(lru_q[idx_e]);
        end
    end

    // On retarget/allocate the selected counter starts from WNT before applying the outcome.
    always_comb begin
        cnt_e_new = cnt_e_old;
        if (is_jump) begin
            cnt_e_new = 2'b11;
        end else if (reinit) begin
            cnt_e_new = taken_e ? 2'b10 : 2'b00;
        end else if (taken_e) begin
            cnt_e_new = (cnt_e_old == 2'b11) ? 2'b11 : cnt_e_old + 2'b01;
        end else begin
            cnt_e_new = (cnt_e_old == 2'b00) ? 2'b00 : cnt_e_old - 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[w][s]  <= 1'b0;
                    tag_q[w][s]    <= '0;
                    target_q[w][s] <= 32'h0;
                    for (int l = 0; l < LOCALS; l++) begin
                        cnt_q[w][s][l] <= 2'b01;
                    end
                end
            end
        end else if (do_update) begin
            valid_q[victim][idx_e] <= 1'b1;
            tag_q[victim][idx_e]   <= tag_e;
            if (reinit) begin
                target_q[victim][idx_e] <= pc_target_e_i;
                for (int l = 0; l < LOCALS; l++) begin
                    cnt_q[victim][idx_e][l] <= 2'b01;
                end
            end
            cnt_q[victim][idx_e][local_src_i] <= cnt_e_new;
            lru_q[idx_e] <= (WAYS == 2) ? ~victim[0] : 1'b0;
        end
    end

`ifdef BTB_STATS_EN
    logic pred_e, mispredict_e;
    assign pred_e       = hit_e & cnt_e_old[1];
    assign mispredict_e = (pred_e != taken_e) | (taken_e & reinit);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            update_cnt_o     <= 32'h0;
            mispredict_cnt_o <= 32'h0;
        end else if (do_update) begin
            if (update_cnt_o != 32'hFFFF_FFFF) update_cnt_o <= update_cnt_o + 32'h1;
            if (mispredict_e && mispredict_cnt_o != 32'hFFFF_FFFF) begin
                mispredict_cnt_o <= mispredict_cnt_o + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer_assoc.sv
// Directed self-checking bench for branch_target_buffer_assoc (default 2-way configuration).
module tb_branch_target_buffer_assoc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_f, pc_e, pc_target_e;
    logic [1:0]  local_src, branch_op;
    logic        pc_src_res, target_match;
    logic        pred, hit;
    logic [31:0] target;
`ifdef BTB_STATS_EN
    logic [31:0] update_cnt, mispredict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_target_buffer_assoc dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .pc_f_i             (pc_f),
        .pc_e_i             (pc_e),
        .pc_target_e_i      (pc_target_e),
        .local_src_i        (local_src),
        .branch_op_e_i      (branch_op),
        .pc_src_res_e_i     (pc_src_res),
        .target_match_i     (target_match),
        .pc_src_pred_f_o    (pred),
        .pred_pc_target_f_o (target),
        .hit_f_o            (hit)
`ifdef BTB_STATS_EN
        ,
        .update_cnt_o       (update_cnt),
        .mispredict_cnt_o   (mispredict_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic [1:0] ls);
        pc_f      = pc;
        local_src = ls;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic h, input logic p,
                              input logic [31:0] t);
        check({tag, ".hit"}, {31'b0, hit}, {31'b0, h});
        check({tag, ".pred"}, {31'b0, pred}, {31'b0, p});
        check({tag, ".target"}, target, t);
    endtask

    // Drive one E-stage update across the next rising edge, then return to idle.
    task automatic update(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic res, input logic match, input logic [1:0] ls);
        branch_op    = op;
        pc_e         = pc;
        pc_target_e  = tgt;
        pc_src_res   = res;
        target_match = match;
        local_src    = ls;
        @(posedge clk);
        #1;
        branch_op = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        {pc_f, pc_e, pc_target_e, local_src, branch_op, pc_src_res, target_match} = '0;
        #3;
        expect_out("rst_pc0", 1'b0, 1'b0, 32'h0);
        look(32'h100, 2'd0);
        expect_out("rst_pc100", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        expect_out("idle", 1'b0, 1'b0, 32'h0);

        update(2'b01, 32'h40, 32'h200, 1'b1, 1'b0, 2'd0);
        look(32'h40, 2'd0);
        expect_out("alloc_ls0", 1'b1, 1'b1, 32'h200);
        look(32'h40, 2'd1);
        expect_out("alloc_ls1", 1'b1, 1'b0, 32'h200);

        // 10 -> 11 -> 11 -> 11, then 11 -> 10, then 10 -> 01
        repeat (3) update(2'b01, 32'h40, 32'h200, 1'b1, 1'b1, 2'd0);
        update(2'b01, 32'h40, 32'h200, 1'b0, 1'b1, 2'd0);
        look(32'h40, 2'd0);
        check("sat_nt1", {31'b0, pred}, 32'd1);
        update(2'b01, 32'h40, 32'h200, 1'b0, 1'b1, 2'd0);
        look(32'h40, 2'd0);
        check("sat_nt2", {31'b0, pred}, 32'd0);

        update(2'b01, 32'h140, 32'h500, 1'b1, 1'b0, 2'd0);
        look(32'h140, 2'd0);
        expect_out("lru_alloc140", 1'b1, 1'b1, 32'h500);
        update(2'b01, 32'h40, 32'h200, 1'b1, 1'b1, 2'd0);
        // Same-cycle F read of the entry being allocated sees old contents.
        pc_f = 32'h240;
        branch_op = 2'b01; pc_e = 32'h240; pc_target_e = 32'h600;
        pc_src_res = 1'b1; target_match = 1'b0; local_src = 2'd0;
        #1;
        check("bypass_old", {31'b0, hit}, 32'd0);
        @(posedge clk);
        #1;
        branch_op = 2'b00;
        look(32'h140, 2'd0);
        check("lru_evict140", {31'b0, hit}, 32'd0);
        look(32'h40, 2'd0);
        expect_out("lru_keep40", 1'b1, 1'b1, 32'h200);
        look(32'h240, 2'd0);
        expect_out("lru_new240", 1'b1, 1'b1, 32'h600);

        update(2'b01, 32'h40, 32'h300, 1'b0, 1'b0, 2'd2);
        for (int l = 0; l < 4; l++) begin
            look(32'h40, 2'(l));
            expect_out($sformatf("retarget_ls%0d", l), 1'b1, 1'b0, 32'h300);
        end

        reset_n = 1'b0;
        #1;
        look(32'h40, 2'd0);
        expect_out("async_rst", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        update(2'b10, 32'h80, 32'h900, 1'b0, 1'b0, 2'd0);
        look(32'h80, 2'd0);
        expect_out("jump_ls0", 1'b1, 1'b1, 32'h900);
        look(32'h80, 2'd1);
        check("jump_ls1", {31'b0, pred}, 32'd0);
`ifdef BTB_STATS_EN
        check("stats_upd1", update_cnt, 32'd1);
        check("stats_mis1", mispredict_cnt, 32'd1);
`endif
        update(2'b10, 32'h80, 32'h900, 1'b0, 1'b1, 2'd0);
`ifdef BTB_STATS_EN
        check("stats_upd2", update_cnt, 32'd2);
        check("stats_mis2", mispredict_cnt, 32'd1);
`endif
        update(2'b11, 32'h80, 32'hABC, 1'b0, 1'b0, 2'd0);
        look(32'h80, 2'd0);
        expect_out("op11_noop", 1'b1, 1'b1, 32'h900);
        update(2'b00, 32'hC0, 32'hABC, 1'b1, 1'b0, 2'd0);
        look(32'hC0, 2'd0);
        check("op00_noop", {31'b0, hit}, 32'd0);

        // Reset held across an update edge discards that update.
        branch_op = 2'b01; pc_e = 32'hC0; pc_target_e = 32'h700;
        pc_src_res = 1'b1; target_match = 1'b0; local_src = 2'd0;
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        branch_op = 2'b00;
        reset_n = 1'b1;
        look(32'hC0, 2'd0);
        expect_out("rst_mid_upd", 1'b0, 1'b0, 32'h0);
        look(32'h80, 2'd0);
        check("rst_mid_old", {31'b0, hit}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
